glb_iact_rd_sched: RTL and testbench
====================================

# glb_iact_rd_sched

Read scheduler for the input-activation global buffer. Two requesters (PE-cluster feeders) each submit burst read commands (base address, length); the block arbitrates round-robin, drives the GLB read port with consecutive addresses, and re-aligns the GLB's registered read data into a 4-entry output FIFO with valid/ready backpressure. It sits between the iact GLB and the iact scratchpad fill logic.

## Interface

- DATA_BITWIDTH, 16, GLB word width
- ADDR_BITWIDTH, 10, GLB address width (2^ADDR_BITWIDTH words)
- LEN_BITWIDTH, 6, burst length field width
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req0_valid / req1_valid  input  1  command valid, requester 0 / 1
- req0_ready / req1_ready  output  1  command accepted when valid & ready
- req0_base / req1_base  input  ADDR_BITWIDTH  burst start address
- req0_len / req1_len  input  LEN_BITWIDTH  number of words (0 = empty burst)
- glb_read_req  output  1  GLB read enable
- glb_r_addr  output  ADDR_BITWIDTH  GLB read address
- glb_r_data  input  DATA_BITWIDTH  GLB read data, valid one cycle after glb_read_req
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_data  output  DATA_BITWIDTH  FIFO head data
- out_id  output  1  requester that owns the head beat
- out_last  output  1  head is final beat of its burst
- busy  output  1  state != IDLE

## Operation

- States: IDLE, BURST, DRAIN.
- IDLE: grant computed combinationally. One valid -> that one; both valid -> requester not granted last (rr pointer, reset value 1 so requester 0 wins first tie). req*_ready high only for granted requester, only in IDLE, 0 during reset.
- On handshake: latch base into addr counter, len into remaining counter, id into cur_id; flip rr pointer to granted id. len != 0 -> BURST; len == 0 -> stay IDLE, no reads, no output beats.
- BURST: glb_read_req=1 when (fifo_count + rd_pending) < 4. Each issue: glb_r_addr = addr counter, addr += 1 modulo 2^ADDR_BITWIDTH (wraps 1023 -> 0), remaining -= 1. Issue of final word (remaining == 1) -> DRAIN.
- rd_pending: registered copy of glb_read_req, carrying id and last flag. When rd_pending=1, glb_r_data is pushed to FIFO with {cur_id, last}. glb_r_data is ignored when rd_pending=0 (GLB drives a non-data default value then).
- DRAIN: no issues; -> IDLE when rd_pending=0 and FIFO empty (after final pop).
- FIFO: 4 entries, {data, id, last}. Pop when out_valid & out_ready. Push and pop in same cycle allowed, count unchanged. Never overflows by the issue rule.
- glb_r_addr registered; holds last value when glb_read_req=0.
- Reset (asynchronous, any state, mid-burst included): state IDLE, rr pointer 1, counters 0, rd_pending 0, FIFO emptied and storage cleared; outputs req*_ready 0, glb_read_req 0, glb_r_addr 0, out_valid 0, out_data 0, out_id 0, out_last 0, busy 0. In-flight GLB data discarded.

## Timing

- Cycle 0: command handshake. Cycle 1: first glb_read_req/glb_r_addr=base. Cycle 2: glb_r_data valid, pushed at end of cycle. Cycle 3: first out_valid.
- With out_ready held 1: one read issued and one beat delivered per cycle; N-word burst occupies cycles 1..N reads, beats 3..N+2, busy deasserts cycle N+3, next command accepted cycle N+3.
- out_ready low: reads stop once fifo_count + rd_pending reaches 4; resume the cycle after a pop frees space.
- busy registered from state; IDLE -> BURST visible cycle 1.

## Test plan

- Reset check: assert reset mid-burst (base 0x010, len 8, after 3 beats) -> all outputs 0 immediately, no further glb_read_req; next command base 0x020 len 2 returns mem[0x020], mem[0x021] only.
- Single burst: req0 base 0x005 len 4, out_ready=1 -> glb_r_addr 5,6,7,8 in cycles 1-4, out_data mem[5..8] cycles 3-6, out_last only on mem[8], out_id 0.
- Arbitration: both valid every IDLE cycle, len 2 each -> grants 0,1,0,1; out_id sequence 0,0,1,1,0,0,1,1.
- Wrap: req1 base 0x3FE len 4 -> addresses 0x3FE,0x3FF,0x000,0x001, out_id 1.
- Backpressure: len 10, out_ready=0 for 8 cycles after cycle 1 -> exactly 4 reads issued, out_valid held with mem[base]; release -> remaining 6 delivered in order, no loss or duplicate.
- Empty burst: req0 len 0 -> ready handshake, no glb_read_req, no out_valid, busy stays 0; req1 next cycle accepted.

Source files
------------

// File: rtl/glb_iact_rd_sched.sv
// Read scheduler for the iact global buffer.
// Two requesters take turns (round-robin) to issue read bursts. The block walks
// consecutive GLB addresses and re-aligns the GLB's one-cycle-late read data
// into a 4-entry output FIFO with valid/ready backpressure.
module glb_iact_rd_sched #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int LEN_BITWIDTH  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [ADDR_BITWIDTH-1:0] req0_base,
  input  logic [LEN_BITWIDTH-1:0]  req0_len,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [ADDR_BITWIDTH-1:0] req1_base,
  input  logic [LEN_BITWIDTH-1:0]  req1_len,
  output logic                     glb_read_req,
  output logic [ADDR_BITWIDTH-1:0] glb_r_addr,
  input  logic [DATA_BITWIDTH-1:0] glb_r_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     out_id,
  output logic                     out_last,
  output logic                     busy
);

  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Arbitration / command
  logic                     rr_ptr;        // id granted last; tie goes to the other one
  logic                     grant0, grant1;
  logic                     accept;
  logic                     acc_id;
  logic [ADDR_BITWIDTH-1:0] acc_base;
  logic [LEN_BITWIDTH-1:0]  acc_len;

  // Burst walk
  logic [ADDR_BITWIDTH-1:0] addr_cnt;
  logic [LEN_BITWIDTH-1:0]  remaining;
  logic                     cur_id;
  logic                     issue;
  logic                     issue_last;

  // One read in flight inside the GLB
  logic                     rd_pending;
  logic                     rd_pend_id;
  logic                     rd_pend_last;

  // Output FIFO
  logic [DATA_BITWIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                     fifo_id   [FIFO_DEPTH];
  logic                     fifo_last [FIFO_DEPTH];
  logic [1:0]               wr_ptr, rd_ptr;
  logic [2:0]               fifo_count;
  logic [2:0]               inflight;
  logic                     push, pop;

  // Round-robin grant, only offered while idle and out of reset
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = rr_ptr;
        grant1 = !rr_ptr;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign acc_id     = grant1;
  assign acc_base   = grant1 ? req1_base : req0_base;
  assign acc_len    = grant1 ? req1_len  : req0_len;

  // Throttle issue so FIFO occupancy plus the beat still inside the GLB never exceeds depth
  assign inflight   = fifo_count + 3'(rd_pending);
  assign issue      = (state == BURST) && (inflight < 3'(FIFO_DEPTH));
  assign issue_last = issue && (remaining == LEN_BITWIDTH'(1));

  assign push = rd_pending;
  assign pop  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: leave DRAIN in the same cycle the final beat is popped
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && acc_len != '0) state_nxt = BURST;
      BURST:   if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (!rd_pending && (fifo_count == 3'd0 || (fifo_count == 3'd1 && pop)))
                 state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, address/length counters and the in-flight read tag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= 1'b1;
      addr_cnt     <= '0;
      remaining    <= '0;
      cur_id       <= 1'b0;
      rd_pending   <= 1'b0;
      rd_pend_id   <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      rd_pending   <= issue;
      rd_pend_id   <= cur_id;
      rd_pend_last <= issue_last;
      if (accept) begin
        rr_ptr    <= acc_id;
        addr_cnt  <= acc_base;
        remaining <= acc_len;
        cur_id    <= acc_id;
      end else if (issue) begin
        addr_cnt  <= addr_cnt + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  // The address counter register doubles as the GLB address port: it only moves on an
  // issue or a new command, so it holds steady while reads are throttled.
  assign glb_read_req = issue;
  assign glb_r_addr   = addr_cnt;

  // Output FIFO storage and pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_id[i]   <= 1'b0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= glb_r_data;
        fifo_id[wr_ptr]   <= rd_pend_id;
        fifo_last[wr_ptr] <= rd_pend_last;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  assign out_valid = (fifo_count != 3'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_id    = fifo_id[rd_ptr];
  assign out_last  = fifo_last[rd_ptr];
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_glb_iact_rd_sched.sv
// Self-checking bench for glb_iact_rd_sched: directed scenarios plus random traffic,
// checked against a command-level model (address list and beat list per accepted burst).
module tb_glb_iact_rd_sched;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_base, req1_base;
  logic [LW-1:0] req0_len, req1_len;
  logic          glb_read_req;
  logic [AW-1:0] glb_r_addr;
  logic [DW-1:0] glb_r_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          out_id, out_last;
  logic          busy;

  always #5 clk = ~clk;

  glb_iact_rd_sched #(
    .DATA_BITWIDTH(DW),
    .ADDR_BITWIDTH(AW),
    .LEN_BITWIDTH (LW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_base   (req0_base),
    .req0_len    (req0_len),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_base   (req1_base),
    .req1_len    (req1_len),
    .glb_read_req(glb_read_req),
    .glb_r_addr  (glb_r_addr),
    .glb_r_data  (glb_r_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_id      (out_id),
    .out_last    (out_last),
    .busy        (busy)
  );

  // GLB: registered read, non-data filler when not reading
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk) glb_r_data <= glb_read_req ? mem[glb_r_addr] : 16'hDEAD;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [AW-1:0] addr_q [$];
  logic [17:0]   beat_q [$];
  int            id_log [$];
  bit            m_idle = 1'b1;
  bit            m_rr   = 1'b1;
  int            m_left = 0;
  int            issued = 0;
  int            popped = 0;
  int            beats_seen = 0;
  int            accepts = 0;

  // Per-cycle observations
  bit            obs_hs0, obs_hs1, obs_rd, obs_valid, obs_busy;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called once per cycle at the falling edge
  task automatic sample();
    bit            e0, e1;
    logic          id;
    logic [AW-1:0] base;
    int            len;
    obs_hs0   = req0_valid & req0_ready;
    obs_hs1   = req1_valid & req1_ready;
    obs_rd    = glb_read_req;
    obs_addr  = glb_r_addr;
    obs_valid = out_valid;
    obs_data  = out_data;
    obs_busy  = busy;
    if (!reset) begin
      addr_q.delete();
      beat_q.delete();
      m_idle = 1'b1;
      m_rr   = 1'b1;
      m_left = 0;
      issued = 0;
      popped = 0;
      return;
    end
    e0 = 1'b0;
    e1 = 1'b0;
    if (m_idle) begin
      if (req0_valid && req1_valid) begin
        e0 = m_rr;
        e1 = !m_rr;
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    check("busy", busy, !m_idle);
    if (glb_read_req) begin
      check("rd_window", (issued - popped) < 4, 1);
      if (addr_q.size() == 0) check("rd_unexpected", glb_read_req, 0);
      else                    check("rd_addr", glb_r_addr, addr_q.pop_front());
      issued++;
    end
    if (out_valid && out_ready) begin
      if (beat_q.size() == 0) check("beat_unexpected", out_valid, 0);
      else                    check("beat", {out_data, out_id, out_last}, beat_q.pop_front());
      popped++;
      beats_seen++;
      id_log.push_back(int'(out_id));
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_idle = 1'b1;
      end
    end
    if (obs_hs0 || obs_hs1) begin
      id   = obs_hs1;
      base = id ? req1_base : req0_base;
      len  = id ? int'(req1_len) : int'(req0_len);
      m_rr = id;
      accepts++;
      for (int i = 0; i < len; i++) begin
        addr_q.push_back(AW'(int'(base) + i));
        beat_q.push_back({mem[AW'(int'(base) + i)], id, i == len - 1});
      end
      if (len != 0) begin
        m_idle = 1'b0;
        m_left = len;
      end
    end
  endtask

  // Sample this cycle, then move to just after the next rising edge
  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero();
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rd_req", glb_read_req, 0);
    check("rst_rd_addr", glb_r_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic send(input int who, input logic [AW-1:0] base, input logic [LW-1:0] len,
                      output int waits);
    bit hs;
    waits = 0;
    if (who == 0) begin req0_valid = 1'b1; req0_base = base; req0_len = len; end
    else          begin req1_valid = 1'b1; req1_base = base; req1_len = len; end
    do begin
      step();
      waits++;
      hs = (who == 0) ? obs_hs0 : obs_hs1;
    end while (!hs && waits < 200);
    check("send_accept", hs, 1);
    if (who == 0) req0_valid = 1'b0;
    else          req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(m_idle && beat_q.size() == 0) && n < 500) begin
      step();
      n++;
    end
    check("drain_done", beat_q.size(), 0);
    step();
  endtask

  function automatic logic [LW-1:0] rand_len();
    if ($urandom_range(9) == 0) return LW'($urandom_range(63));
    return LW'($urandom_range(8));
  endfunction

  initial begin
    int w, n, start, logsz, rd_cnt, b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    reset      = 1'b0;
    req0_valid = 1'b0; req0_base = '0; req0_len = '0;
    req1_valid = 1'b0; req1_base = '0; req1_len = '0;
    out_ready  = 1'b1;
    #1;
    check_zero();
    step();
    step();
    reset = 1'b1;
    step();

    // Single burst with exact cycle timing
    send(0, 10'h005, 4, w);
    for (int k = 1; k <= 7; k++) begin
      step();
      check("sb_rd", obs_rd, k <= 4);
      if (k <= 4) check("sb_addr", obs_addr, 5 + k - 1);
      check("sb_valid", obs_valid, k >= 3 && k <= 6);
      check("sb_busy", obs_busy, k <= 6);
    end
    wait_idle();

    // Address wrap on requester 1
    send(1, 10'h3FE, 4, w);
    wait_idle();

    // Both requesters always valid: grants alternate
    start = accepts;
    logsz = id_log.size();
    req0_valid = 1'b1; req0_base = 10'h100; req0_len = 2;
    req1_valid = 1'b1; req1_base = 10'h200; req1_len = 2;
    n = 0;
    while (accepts < start + 4 && n < 200) begin
      step();
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 8; i++)
      check("arb_id", (id_log.size() > logsz + i) ? id_log[logsz + i] : 9, (i / 2) % 2);

    // Backpressure: reads stop at four outstanding
    out_ready = 1'b0;
    send(0, 10'h040, 10, w);
    rd_cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      rd_cnt += int'(obs_rd);
    end
    check("bp_reads", rd_cnt, 4);
    check("bp_valid", obs_valid, 1);
    check("bp_head", obs_data, mem[10'h040]);
    out_ready = 1'b1;
    wait_idle();

    // Empty burst, then the other requester the very next cycle
    send(0, 10'h080, 0, w);
    req1_valid = 1'b1; req1_base = 10'h090; req1_len = 2;
    step();
    check("empty_next_accept", obs_hs1, 1);
    check("empty_no_rd", obs_rd, 0);
    check("empty_no_valid", obs_valid, 0);
    check("empty_busy", obs_busy, 0);
    req1_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a burst
    b0 = beats_seen;
    send(0, 10'h010, 8, w);
    n = 0;
    while (beats_seen < b0 + 3 && n < 50) begin
      step();
      n++;
    end
    reset = 1'b0;
    #1;
    check_zero();
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_no_rd", obs_rd, 0);
    end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) step();
    b0 = beats_seen;
    send(0, 10'h020, 2, w);
    wait_idle();
    check("rst_after_beats", beats_seen - b0, 2);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      if (req0_valid && obs_hs0) req0_valid = 1'b0;
      if (!req0_valid && $urandom_range(2) == 0) begin
        req0_valid = 1'b1; req0_base = AW'($urandom); req0_len = rand_len();
      end
      if (req1_valid && obs_hs1) req1_valid = 1'b0;
      if (!req1_valid && $urandom_range(2) == 0) begin
        req1_valid = 1'b1; req1_base = AW'($urandom); req1_len = rand_len();
      end
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    if (req0_valid && obs_hs0) req0_valid = 1'b0;
    if (req1_valid && obs_hs1) req1_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    // a command still pending after the loop may have been accepted in wait_idle's last step
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    check("final_addr_q", addr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
